// File: rtl/ysyx_24110015_ifu_fetch.sv
// ============================================================================
// ysyx_24110015_ifu_fetch : instruction fetch FSM with an in-order instruction buffer
// Optional: define YSYX_24110015_IFU_MISALIGN_CHK_EN to raise alignment faults. Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_24110015_ifu_fetch #(
  parameter int             XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int             BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_fault
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      boot_q, boot_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
  logic            halt_q, halt_d;
`endif

  logic [XLEN-1:0] pc_mem_q   [BUF_DEPTH];
  logic [XLEN-1:0] inst_mem_q [BUF_DEPTH];
  logic            flt_mem_q  [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic            push, pop, full;
  logic [XLEN-1:0] push_inst;
  logic            push_flt;

  assign full      = (count_q == CNT_W'(BUF_DEPTH));
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_inst  = inst_mem_q[rd_ptr_q];
  assign out_fault = flt_mem_q[rd_ptr_q];
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    push        = 1'b0;
    push_inst   = mem_rsp_data;
    push_flt    = mem_rsp_err;
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
    halt_d      = halt_q;
`endif
    // Two-cycle holdoff after reset release before the first request
    if (boot_q != 2'd2) boot_d = boot_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && !full && boot_q == 2'd2) begin
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
          if (!halt_q) begin
            if (fetch_pc_q[1:0] != 2'b00) begin
              push      = 1'b1;
              push_inst = '0;
              push_flt  = 1'b1;
              halt_d    = 1'b1;
            end else begin
              state_d     = S_REQ;
              req_valid_d = 1'b1;
              req_addr_d  = fetch_pc_q;
            end
          end
`else
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          req_addr_d  = {fetch_pc_q[XLEN-1:2], 2'b00};
`endif
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          kill_d      = 1'b0;
          state_d     = (kill_q || redirect_valid) ? S_DROP : S_WAIT;
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = mem_rsp_valid ? S_IDLE : S_DROP;
        end else if (mem_rsp_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
      halt_d     = 1'b0;
`endif
    end
  end

  always_comb begin
    count_d = count_q;
    if (redirect_valid)    count_d = '0;
    else if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      boot_q      <= 2'd0;
      fetch_pc_q  <= RESET_PC;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
      halt_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
      halt_q      <= halt_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
        flt_mem_q[i]  <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
          inst_mem_q[wr_ptr_q] <= push_inst;
          flt_mem_q[wr_ptr_q]  <= push_flt;
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110015_ifu_fetch.sv
// ============================================================================
// tb_ysyx_24110015_ifu_fetch : directed self-checking bench for the fetch unit
// ============================================================================
`default_nettype none

module tb_ysyx_24110015_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24110015_ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd1);
    check({tag, "_req_addr"}, mem_req_addr, addr);
  endtask

  // Accept one request and answer it in the following cycle
  task automatic serve(input string tag, input logic [31:0] addr,
                       input logic [31:0] data, input logic err);
    wait_req(tag, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    mem_rsp_err   = err;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [31:0] drain_inst [4];
    drain_inst[0] = 32'h0010_0093;
    drain_inst[1] = 32'h0020_0113;
    drain_inst[2] = 32'h0030_0193;
    drain_inst[3] = 32'h0040_0213;

    #12;
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_fault", {31'b0, out_fault}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    tick();
    check("boot_e1_valid", {31'b0, mem_req_valid}, 32'd0);
    tick();
    check("boot_e2_valid", {31'b0, mem_req_valid}, 32'd0);
    tick();
    check("boot_e3_valid", {31'b0, mem_req_valid}, 32'd1);

    serve("first", 32'h8000_0000, 32'h0000_0413, 1'b0);
    check("first_out_valid", {31'b0, out_valid}, 32'd1);
    check("first_out_pc", out_pc, 32'h8000_0000);
    check("first_out_inst", out_inst, 32'h0000_0413);
    check("first_out_fault", {31'b0, out_fault}, 32'd0);

    serve("fill1", 32'h8000_0004, drain_inst[0], 1'b0);
    serve("fill2", 32'h8000_0008, drain_inst[1], 1'b0);
    serve("fill3", 32'h8000_000C, drain_inst[2], 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | mem_req_valid;
    end
    check("full_no_req", {31'b0, seen}, 32'd0);
    check("full_head_pc", out_pc, 32'h8000_0000);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop1_pc", out_pc, 32'h8000_0004);
    check("pop1_inst", out_inst, drain_inst[0]);
    serve("fill4", 32'h8000_0010, drain_inst[3], 1'b0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("drain%0d_pc", i), out_pc, 32'h8000_0004 + 32'(4 * i));
      check($sformatf("drain%0d_inst", i), out_inst, drain_inst[i]);
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", {31'b0, out_valid}, 32'd0);
    check("held_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("held_req_addr", mem_req_addr, 32'h8000_0014);

    // Redirect while the request is stalled
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    check("r024_addr0", mem_req_addr, 32'h8000_0014);
    tick();
    check("r024_addr1", mem_req_addr, 32'h8000_0014);
    tick();
    check("r024_addr2", mem_req_addr, 32'h8000_0014);
    check("r024_valid2", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("r024_req_drop", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    check("r024_dropped", {31'b0, out_valid}, 32'd0);
    serve("r024", 32'h8000_2000, 32'h0050_0293, 1'b0);
    check("r024_out_pc", out_pc, 32'h8000_2000);
    check("r024_out_inst", out_inst, 32'h0050_0293);

    // Redirect while waiting for a response
    wait_req("r023a", 32'h8000_2004);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    check("r023_flush", {31'b0, out_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_0001;
    tick();
    mem_rsp_valid = 1'b0;
    check("r023_dropped", {31'b0, out_valid}, 32'd0);
    serve("r023", 32'h8000_1000, 32'h00A0_0513, 1'b0);
    check("r023_out_pc", out_pc, 32'h8000_1000);
    check("r023_out_inst", out_inst, 32'h00A0_0513);

    // Redirect together with a response and a pop
    wait_req("r013a", 32'h8000_1004);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'hBAD0_0002;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    out_ready      = 1'b0;
    check("r013_flush", {31'b0, out_valid}, 32'd0);
    tick();
    check("r013_no_push", {31'b0, out_valid}, 32'd0);

    serve("r025", 32'h8000_3000, 32'h0000_0073, 1'b1);
    check("r025_fault", {31'b0, out_fault}, 32'd1);
    check("r025_pc", out_pc, 32'h8000_3000);
    serve("r025b", 32'h8000_3004, 32'h0010_0073, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("r025b_pc", out_pc, 32'h8000_3004);
    check("r025b_fault", {31'b0, out_fault}, 32'd0);
    check("r025b_inst", out_inst, 32'h0010_0073);

    // Misaligned redirect target
    wait_req("mis_a", 32'h8000_3008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_4002;
    tick();
    redirect_valid = 1'b0;
    check("mis_flush", {31'b0, out_valid}, 32'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_0003;
    tick();
    mem_rsp_valid = 1'b0;
`ifdef YSYX_24110015_IFU_MISALIGN_CHK_EN
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | mem_req_valid;
    end
    check("mis_no_req", {31'b0, seen}, 32'd0);
    check("mis_valid", {31'b0, out_valid}, 32'd1);
    check("mis_fault", {31'b0, out_fault}, 32'd1);
    check("mis_pc", out_pc, 32'h8000_4002);
`else
    serve("mis", 32'h8000_4000, 32'h0000_0013, 1'b0);
    check("mis_pc", out_pc, 32'h8000_4002);
    check("mis_fault", {31'b0, out_fault}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
